// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle controller and its shared-memory datapath.
// The controller side is the master; the datapath (and any bench) is the slave.
interface mc_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;

  logic       mem_req;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic       illegal_op;
  logic [3:0] state_dbg;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ALUControl, ImmSrc, RegWrite, illegal_op, state_dbg
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ALUControl, ImmSrc, RegWrite, illegal_op, state_dbg
  );
endinterface

// File: rtl/mc_controller.sv
// Moore FSM sequencing a unified-memory RV32I-subset datapath; 3-5 cycles per instruction.
// Stalls in FETCH/MEMREAD/MEMWRITE until mem_ready, holding every output stable meanwhile.
module mc_controller (
  input  logic           clk,
  input  logic           reset,
  mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_e     state_q, state_d;
  logic [1:0] alu_op;
  logic       mem_req, pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    mem_req    = 1'b0;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      S_FETCH: begin
        // PC+4 is formed and latched in the same cycle the instruction lands
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.mem_ready;
        pc_write   = bus.mem_ready;
        state_d    = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // OldPC+4 goes to rd via ALUWB while the jump target from DECODE loads PC
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = 2'b01;
        pc_write  = bus.zero;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      2'b01: alu_control = ALU_SUB;
      2'b10: begin
        case (bus.funct3)
          3'b000:  alu_control = (bus.op[5] & bus.funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  assign bus.mem_req    = mem_req;
  assign bus.PCWrite    = pc_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_write;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = imm_src;
  assign bus.RegWrite   = reg_write;
  assign bus.illegal_op = illegal_op;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction step lists drive a reference model checked every cycle,
// plus literal expectations for the directed scenarios and an abort-by-reset scenario.
module tb_mc_controller;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_controller_if bus();
  mc_controller dut (.clk(clk), .reset(reset), .bus(bus));

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RTY  = 7'b0110011;
  localparam logic [6:0] ITY  = 7'b0010011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] SYS  = 7'b1110011;

  int n_checks = 0;
  int n_pass   = 0;

  int     steps[$];
  longint trace;
  int     mw_cycles, rw_count, pcw_count, ill_count, alu_exec, imm_seen;

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Instruction semantics: which ALU operation the instruction itself asks for
  function automatic logic [2:0] exec_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (op == RTY && f7) ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [21:0] expected(input int step, input logic [6:0] op, input logic [2:0] f3,
                                           input logic f7, input logic z, input logic rdy);
    logic mreq, pcw, adr, mw, irw, rw, ill;
    logic [1:0] res, srca, srcb, imm;
    logic [2:0] alu;
    logic [3:0] st;
    mreq = 0; pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    res = 0; srca = 0; srcb = 0; alu = 0;
    st = step[3:0];
    case (step)
      0:  begin mreq = 1; srcb = 2; res = 2; irw = rdy; pcw = rdy; end
      1:  begin srca = 1; srcb = 1; ill = !(op inside {LW, SW, RTY, ITY, JAL, BEQ}); end
      2:  begin srca = 2; srcb = 1; end
      3:  begin mreq = 1; adr = 1; end
      4:  begin res = 1; rw = 1; end
      5:  begin mreq = 1; adr = 1; mw = 1; end
      6:  begin srca = 2; srcb = 0; alu = exec_alu(op, f3, f7); end
      7:  begin srca = 2; srcb = 1; alu = exec_alu(op, f3, f7); end
      8:  rw = 1;
      9:  begin srca = 2; srcb = 0; alu = 3'd1; pcw = z; end
      10: begin srca = 1; srcb = 2; pcw = 1; end
      default: ;
    endcase
    imm = (op == SW) ? 2'd1 : (op == BEQ) ? 2'd2 : (op == JAL) ? 2'd3 : 2'd0;
    return {mreq, pcw, adr, mw, irw, res, srca, srcb, alu, imm, rw, ill, st};
  endfunction

  function automatic logic [21:0] observed();
    return {bus.mem_req, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
            bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.RegWrite,
            bus.illegal_op, bus.state_dbg};
  endfunction

  task automatic build_steps(input logic [6:0] op);
    case (op)
      LW:      steps = '{0, 1, 2, 3, 4};
      SW:      steps = '{0, 1, 2, 5};
      RTY:     steps = '{0, 1, 6, 8};
      ITY:     steps = '{0, 1, 7, 8};
      JAL:     steps = '{0, 1, 10, 8};
      BEQ:     steps = '{0, 1, 9};
      default: steps = '{0, 1};
    endcase
  endtask

  // Entered at posedge+1 with the DUT in FETCH; leaves it the same way.
  task automatic run_instr(input logic [6:0] iop, input logic [2:0] f3, input logic f7,
                           input int ready_pct, input int zero_mode,
                           input int stall_state, input int stall_n);
    int stall_left;
    int cyc;
    logic rdy, z;
    logic [21:0] exp, got;
    stall_left = stall_n;
    cyc = 0;
    build_steps(iop);
    bus.op = iop; bus.funct3 = f3; bus.funct7b5 = f7;
    trace = 0; mw_cycles = 0; rw_count = 0; pcw_count = 0; ill_count = 0;
    alu_exec = -1; imm_seen = -1;
    while (steps.size() > 0) begin
      if (steps[0] == stall_state && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = ($urandom_range(99) < ready_pct);
      end
      z = (zero_mode == 2) ? 1'($urandom_range(1)) : zero_mode[0];
      bus.mem_ready = rdy;
      bus.zero = z;
      @(negedge clk);
      exp = expected(steps[0], iop, f3, f7, z, rdy);
      got = observed();
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL cycle_outputs op=%b step=%0d got=%h expected=%h", iop, steps[0], got, exp);
      trace = (trace << 4) | longint'(bus.state_dbg);
      if (bus.MemWrite)   mw_cycles++;
      if (bus.RegWrite)   rw_count++;
      if (bus.PCWrite)    pcw_count++;
      if (bus.illegal_op) ill_count++;
      if (bus.state_dbg inside {4'd2, 4'd6, 4'd7, 4'd9}) alu_exec = int'(bus.ALUControl);
      imm_seen = int'(bus.ImmSrc);
      @(posedge clk);
      #1;
      if (!(steps[0] inside {0, 3, 5} && !rdy)) void'(steps.pop_front());
      cyc++;
      if (cyc > 200) begin
        $display("FAIL cycle_budget op=%b got %0d cycles expected at most 200", iop, cyc);
        n_checks++;
        steps.delete();
      end
    end
  endtask

  initial begin
    logic [6:0] rop;
    int found;
    reset = 1'b1;
    bus.op = RTY; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    #12;
    chk("reset_state", bus.state_dbg, 0);
    chk("reset_mem_req", bus.mem_req, 1);
    chk("reset_alusrcb", bus.ALUSrcB, 2);
    chk("reset_resultsrc", bus.ResultSrc, 2);
    chk("reset_irwrite_lo", bus.IRWrite, 0);
    chk("reset_regwrite", bus.RegWrite, 0);
    bus.mem_ready = 1'b1;
    #1;
    chk("reset_irwrite_hi", bus.IRWrite, 1);
    chk("reset_pcwrite_hi", bus.PCWrite, 1);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_instr(LW, 3'd2, 1'b0, 100, 0, -1, 0);
    chk("lw_trace", trace, 64'h01234);
    chk("lw_regwrite_count", rw_count, 1);
    chk("lw_memadr_alu", alu_exec, 0);

    run_instr(SW, 3'd2, 1'b0, 100, 0, 5, 3);
    chk("sw_trace", trace, 64'h0125555);
    chk("sw_memwrite_cycles", mw_cycles, 4);
    chk("sw_regwrite_count", rw_count, 0);
    chk("sw_immsrc", imm_seen, 1);

    run_instr(RTY, 3'd0, 1'b1, 100, 0, -1, 0);
    chk("sub_trace", trace, 64'h0168);
    chk("sub_alu", alu_exec, 1);
    run_instr(ITY, 3'd0, 1'b1, 100, 0, -1, 0);
    chk("addi_trace", trace, 64'h0178);
    chk("addi_alu", alu_exec, 0);
    run_instr(RTY, 3'd6, 1'b0, 100, 0, -1, 0);
    chk("or_alu", alu_exec, 3);
    run_instr(ITY, 3'd2, 1'b0, 100, 0, -1, 0);
    chk("slti_alu", alu_exec, 5);
    run_instr(RTY, 3'd7, 1'b0, 100, 0, -1, 0);
    chk("and_alu", alu_exec, 2);

    run_instr(BEQ, 3'd0, 1'b0, 100, 1, -1, 0);
    chk("beq_taken_trace", trace, 64'h019);
    chk("beq_taken_pcwrites", pcw_count, 2);
    chk("beq_alu", alu_exec, 1);
    chk("beq_immsrc", imm_seen, 2);
    run_instr(BEQ, 3'd0, 1'b0, 100, 0, -1, 0);
    chk("beq_nottaken_pcwrites", pcw_count, 1);

    run_instr(SYS, 3'd0, 1'b0, 100, 0, -1, 0);
    chk("illegal_trace", trace, 64'h01);
    chk("illegal_pulses", ill_count, 1);

    run_instr(JAL, 3'd0, 1'b0, 100, 0, -1, 0);
    chk("jal_trace", trace, 64'h01A8);
    chk("jal_pcwrites", pcw_count, 2);
    chk("jal_regwrites", rw_count, 1);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(7))
        0: rop = LW;
        1: rop = SW;
        2: rop = RTY;
        3: rop = ITY;
        4: rop = JAL;
        5: rop = BEQ;
        6: rop = SYS;
        default: rop = 7'($urandom_range(127));
      endcase
      run_instr(rop, 3'($urandom_range(7)), 1'($urandom_range(1)), 60, 2, -1, 0);
    end

    // Abort a store that is waiting on memory
    bus.op = SW; bus.funct3 = 3'd2; bus.mem_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (bus.state_dbg == 4'd5) found = 1;
    end
    chk("abort_reached_memwrite", found, 1);
    bus.mem_ready = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("abort_state", bus.state_dbg, 0);
    chk("abort_memwrite", bus.MemWrite, 0);
    chk("abort_regwrite", bus.RegWrite, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_restart_state", bus.state_dbg, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit that sequences a shared-memory RISC-V datapath (RV32I subset: lw, sw, R-type, I-type ALU, beq, jal) through fetch, decode, execute, memory and writeback steps. The controller is a Moore FSM plus combinational ALU and immediate decoders. It drives every datapath enable and mux select, and stalls on a single memory-ready handshake. It replaces the flat single-cycle decoder when instruction and data memory are unified behind one port.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; forces state to FETCH
- op  in  7  Instr[6:0], taken from the instruction register
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access active (FETCH, MEMREAD, MEMWRITE)
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register (and OldPC) enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 register
- ALUSrcB  out  2  00 = rs2 register, 01 = ImmExt, 10 = constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- RegWrite  out  1  register file write enable
- illegal_op  out  1  one-cycle pulse in DECODE when op is unsupported
- state_dbg  out  4  current state encoding

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10. Encodings 11–15 return to FETCH on the next edge.
- Outputs not listed for a state are 0.
- FETCH: mem_req=1, ALUSrcB=10, ResultSrc=10, ALUOp=00. IRWrite and PCWrite equal mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target computed). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BEQ
  - any other op → FETCH, with illegal_op=1
- MEMADR: ALUSrcA=10, ALUSrcB=01. Next state is MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
- MEMREAD: mem_req=1, AdrSrc=1. Waits for mem_ready, then → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1, held until mem_ready → FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
- ALUWB: RegWrite=1 (ResultSrc=00) → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, PCWrite=1 → ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01. PCWrite=zero. → FETCH.
- ALUOp is internal.
  - 00 → add.
  - 01 → sub.
  - 10 → decode funct3:
    - 000: sub if op[5]&funct7b5, else add
    - 010: slt
    - 110: or
    - 111: and
    - other: add
- ImmSrc is decoded from op in every state: 0100011→01, 1100011→10, 1101111→11, otherwise 00.

## Timing
- Reset asynchronously sets state to FETCH. Outputs are combinational from state, so during reset: mem_req=1, ALUSrcB=10, ResultSrc=10, IRWrite=PCWrite=mem_ready, all other strobes 0.
- Deasserting reset is synchronous to clk.
- Cycle counts with mem_ready tied high:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type, I-type, jal: 4 cycles
  - beq: 3 cycles
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. All outputs hold stable during the wait.
- MemWrite may be asserted for several cycles. The memory commits exactly once, on the edge where mem_ready=1.
- RegWrite is a single-cycle pulse per instruction. PCWrite pulses once in FETCH and at most once more in BEQ or JAL.
- Reset asserted mid-instruction aborts the instruction immediately. No RegWrite or MemWrite is issued after reset asserts.

## Test plan
- Reset asserted in MEMWRITE with mem_ready=0 → state_dbg=0 immediately, MemWrite=0; after release and one cycle with mem_ready=1, state_dbg=1.
- lw (op=0000011), mem_ready=1 → states 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01; ALUControl=000 in MEMADR.
- sw with mem_ready low for 3 cycles in MEMWRITE → MemWrite high 4 cycles, ImmSrc=01, then FETCH; RegWrite never 1.
- R-type sub (funct3=000, funct7b5=1) → ALUControl=001 in EXECR; same with op=0010011 (addi, funct7b5=1) → ALUControl=000.
- beq with zero=1 → PCWrite=1 in BEQ; with zero=0 → PCWrite=0; ALUControl=001, ImmSrc=10.
- op=1110011 in DECODE → illegal_op=1 for one cycle, next state 0; jal → states 0,1,10,8,0 with PCWrite in 10 and RegWrite in 8.
